// File: rtl/tqvp_multi_pwm_pkg.sv
// tqvp_multi_pwm_pkg: shared definitions for the multi-channel PWM peripheral.
// Holds the register map, the CTRL bit positions and the PERIOD reset-value
// helper. It has no ports.
package tqvp_multi_pwm_pkg;

   localparam logic [3:0] ADDR_CTRL       = 4'h0;
   localparam logic [3:0] ADDR_PERIOD     = 4'h1;
   localparam logic [3:0] ADDR_PRESCALE   = 4'h2;
   localparam logic [3:0] ADDR_POLARITY   = 4'h3;
   localparam logic [3:0] ADDR_COUNT      = 4'h4;
   localparam logic [3:0] ADDR_LEVEL_BASE = 4'h8;

   localparam int CTRL_EN_BIT  = 0;
   localparam int CTRL_IRQ_BIT = 1;

   // The default TOP is 2^WIDTH-2. This leaves the all-ones level above TOP,
   // so that level gives a 100% duty cycle.
   function automatic logic [7:0] period_reset(input int width);
      return 8'((1 << width) - 2);
   endfunction

endpackage

// File: rtl/tqvp_multi_pwm_channel.sv
// tqvp_multi_pwm_channel: one PWM output channel.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   en        - peripheral enable; while low, active tracks pending and the
//               output sits at its inactive (polarity) level
//   wrap      - period-wrap strobe from the shared counter
//   count     - shared period counter
//   level_wr  - write strobe for this channel's LEVEL register
//   level_in  - write data, already truncated to WIDTH
//   polarity  - output inversion bit
//   pending   - buffered level (register read-back)
//   pwm       - registered PWM output
module tqvp_multi_pwm_channel #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             wrap,
   input  logic [WIDTH-1:0] count,
   input  logic             level_wr,
   input  logic [WIDTH-1:0] level_in,
   input  logic             polarity,
   output logic [WIDTH-1:0] pending,
   output logic             pwm
);

   logic [WIDTH-1:0] active;

   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= '0;
         active  <= '0;
         pwm     <= 1'b0;
      end else begin
         if (level_wr)
            pending <= level_in;
         // A write landing on the wrap edge misses this load. The wrap takes
         // the old pending value; the new one waits for the next wrap.
         if (!en || wrap)
            active <= pending;
         pwm <= en ? ((count < active) ^ polarity) : polarity;
      end
   end

endmodule

// File: rtl/tqvp_multi_pwm.sv
// tqvp_multi_pwm: multi-channel PWM peripheral for the TinyQV peripheral slot.
// The channels share one prescaled period counter. Each channel has a
// double-buffered duty level and a polarity bit.
// Optional feature: define TQVP_MULTI_PWM_IRQ_EN to add the period-wrap
// interrupt flag. When it is undefined, irq is tied to 0 and CTRL[1] reads 0.
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   ui_in       - input PMOD, reserved (unused)
//   uo_out      - PWM outputs; bit n is channel n, and bits >= NUM_CH read 0
//   address     - register address
//   data_write  - write strobe (data_in is valid)
//   data_in     - write data
//   data_out    - read data, combinational from address
//   irq         - period-wrap interrupt
module tqvp_multi_pwm
   import tqvp_multi_pwm_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int WIDTH  = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [3:0] address,
   input  logic       data_write,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic       irq
);

   localparam logic [7:0] PERIOD_RST = period_reset(WIDTH);

   logic              en;
   logic [WIDTH-1:0]  top;
   logic [WIDTH-1:0]  count;
   logic [7:0]        prescale;
   logic [7:0]        presc_cnt;
   logic [NUM_CH-1:0] polarity;
   logic [NUM_CH-1:0] pwm;
   logic [NUM_CH-1:0] lvl_wr;
   logic [WIDTH-1:0]  pending [NUM_CH];
   logic              tick;
   logic              wrap;
   logic              wr_ctrl;
   logic              irq_flag;
   logic              unused_ui;

   assign unused_ui = ^ui_in;
   assign wr_ctrl   = data_write && (address == ADDR_CTRL);
   assign tick      = en && (presc_cnt == prescale);
   // Use >= rather than == so that lowering TOP below the current count
   // wraps on the next tick instead of running to the top of the counter.
   assign wrap      = tick && (count >= top);

   always_ff @(posedge clk) begin
      if (rst) begin
         en       <= 1'b0;
         top      <= PERIOD_RST[WIDTH-1:0];
         prescale <= 8'h00;
         polarity <= '0;
      end else if (data_write) begin
         case (address)
            ADDR_CTRL:     en       <= data_in[CTRL_EN_BIT];
            ADDR_PERIOD:   top      <= data_in[WIDTH-1:0];
            ADDR_PRESCALE: prescale <= data_in;
            ADDR_POLARITY: polarity <= data_in[NUM_CH-1:0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst || !en) begin
         count     <= '0;
         presc_cnt <= 8'h00;
      end else if (tick) begin
         presc_cnt <= 8'h00;
         count     <= wrap ? '0 : count + 1'b1;
      end else begin
         presc_cnt <= presc_cnt + 8'h01;
      end
   end

`ifdef TQVP_MULTI_PWM_IRQ_EN
   // When a set and a clear arrive in the same cycle, the set wins.
   always_ff @(posedge clk) begin
      if (rst)
         irq_flag <= 1'b0;
      else if (wrap)
         irq_flag <= 1'b1;
      else if (wr_ctrl && data_in[CTRL_IRQ_BIT])
         irq_flag <= 1'b0;
   end
`else
   assign irq_flag = 1'b0;
`endif

   assign irq = irq_flag;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign lvl_wr[g] = data_write && (address == 4'(ADDR_LEVEL_BASE + g));

      tqvp_multi_pwm_channel #(.WIDTH(WIDTH)) u_ch (
         .clk      (clk),
         .rst      (rst),
         .en       (en),
         .wrap     (wrap),
         .count    (count),
         .level_wr (lvl_wr[g]),
         .level_in (data_in[WIDTH-1:0]),
         .polarity (polarity[g]),
         .pending  (pending[g]),
         .pwm      (pwm[g])
      );
   end

   assign uo_out = 8'(pwm);

   always_comb begin
      data_out = 8'h00;
      case (address)
         ADDR_CTRL: begin
            data_out[CTRL_EN_BIT]  = en;
            data_out[CTRL_IRQ_BIT] = irq_flag;
         end
         ADDR_PERIOD:   data_out = 8'(top);
         ADDR_PRESCALE: data_out = prescale;
         ADDR_POLARITY: data_out = 8'(polarity);
         ADDR_COUNT:    data_out = 8'(count);
         default: begin
            for (int n = 0; n < NUM_CH; n++)
               if (address == 4'(ADDR_LEVEL_BASE + n))
                  data_out = 8'(pending[n]);
         end
      endcase
   end

endmodule

// File: tb/tb_tqvp_multi_pwm.sv
`timescale 1ns/1ps
module tb_tqvp_multi_pwm;
   import tqvp_multi_pwm_pkg::*;

   localparam int NUM_CH = 4;
   localparam int WIDTH  = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [3:0] address;
   logic       data_write;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       irq;

   always #5 clk = ~clk;

   tqvp_multi_pwm #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .ui_in      (ui_in),
      .uo_out     (uo_out),
      .address    (address),
      .data_write (data_write),
      .data_in    (data_in),
      .data_out   (data_out),
      .irq        (irq)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   typedef struct {
      string       tag;
      logic [31:0] val;
   } sb_t;
   sb_t sb_q[$];

   task automatic sb_push(input string tag, input logic [31:0] v);
      sb_t e;
      e.tag = tag;
      e.val = v;
      sb_q.push_back(e);
   endtask

   task automatic sb_pop(input logic [31:0] obs);
      sb_t e;
      if (sb_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL sb_empty: got 0x%0h expected none queued", obs);
      end else begin
         e = sb_q.pop_front();
         check(e.tag, obs, e.val);
      end
   endtask

   // Reference model state.
   logic       m_en, m_flag;
   logic [7:0] m_top, m_ps, m_presc, m_cnt, m_pol, m_pwm;
   logic [7:0] m_pend [NUM_CH];
   logic [7:0] m_act  [NUM_CH];

   task automatic model_reset();
      m_en = 0; m_flag = 0; m_top = 8'hFE; m_ps = 0; m_presc = 0;
      m_cnt = 0; m_pol = 0; m_pwm = 0;
      for (int c = 0; c < NUM_CH; c++) begin
         m_pend[c] = 0;
         m_act[c]  = 0;
      end
   endtask

   task automatic model_step(input logic wr, input logic [3:0] a, input logic [7:0] d);
      logic       tk, wp;
      logic [7:0] npwm;
      tk = m_en && (m_presc == m_ps);
      wp = tk && (m_cnt >= m_top);
      npwm = 8'h00;
      for (int c = 0; c < NUM_CH; c++) begin
         npwm[c] = m_en ? ((m_cnt < m_act[c]) ^ m_pol[c]) : m_pol[c];
         if (!m_en || wp) m_act[c] = m_pend[c];
      end
      if (!m_en) begin
         m_cnt = 0; m_presc = 0;
      end else if (tk) begin
         m_presc = 0;
         m_cnt = wp ? 8'h00 : m_cnt + 8'h01;
      end else begin
         m_presc = m_presc + 8'h01;
      end
      m_pwm = npwm;
`ifdef TQVP_MULTI_PWM_IRQ_EN
      if (wp) m_flag = 1;
      else if (wr && a == ADDR_CTRL && d[1]) m_flag = 0;
`endif
      if (wr) begin
         case (a)
            ADDR_CTRL:     m_en  = d[0];
            ADDR_PERIOD:   m_top = d;
            ADDR_PRESCALE: m_ps  = d;
            ADDR_POLARITY: m_pol = d & 8'((1 << NUM_CH) - 1);
            default:
               if (a >= 4'h8 && (int'(a) - 8) < NUM_CH) m_pend[int'(a) - 8] = d;
         endcase
      end
   endtask

   // One clock: drive, let the model predict, then compare uo_out, count and irq.
   task automatic cyc(input logic wr = 1'b0, input logic [3:0] a = ADDR_COUNT,
                      input logic [7:0] d = 8'h00);
      data_write = wr; address = a; data_in = d;
      @(posedge clk);
      model_step(wr, a, d);
      sb_push("uo_out", 32'(m_pwm));
      sb_push("count", 32'(m_cnt));
      sb_push("irq", 32'(m_flag));
      @(negedge clk);
      data_write = 1'b0; address = ADDR_COUNT;
      #1;
      sb_pop(32'(uo_out));
      sb_pop(32'(data_out));
      sb_pop(32'(irq));
   endtask

   task automatic rd_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
      data_write = 1'b0; address = a;
      #1;
      sb_push(tag, 32'(exp));
      sb_pop(32'(data_out));
      address = ADDR_COUNT;
   endtask

   // Step until the model is about to tick with count c.
   task automatic run_to_cnt(input logic [7:0] c, input int max);
      int k = 0;
      while (!(m_cnt == c && m_presc == m_ps) && k < max) begin
         cyc();
         k++;
      end
      if (k >= max) begin
         n_cmp++;
         n_err++;
         $display("FAIL run_to_cnt: count 0x%0h not reached within %0d clks", c, max);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int h0, h1, h2;
      rst = 1'b1; ui_in = 8'h00; data_write = 1'b0; address = ADDR_COUNT; data_in = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_reset();
      #1;

      // Reset state
      rd_chk("rst_ctrl", ADDR_CTRL, 8'h00);
      rd_chk("rst_period", ADDR_PERIOD, 8'hFE);
      rd_chk("rst_prescale", ADDR_PRESCALE, 8'h00);
      rd_chk("rst_polarity", ADDR_POLARITY, 8'h00);
      rd_chk("rst_count", ADDR_COUNT, 8'h00);
      rd_chk("rst_level0", 4'h8, 8'h00);
      rd_chk("rst_level3", 4'hB, 8'h00);
      rd_chk("rst_addr5", 4'h5, 8'h00);
      check("rst_uo", 32'(uo_out), 32'h0);
      check("rst_irq", 32'(irq), 32'h0);

      // Default period, duty 0x80 / 0x00 / 0xFF
      cyc(1'b1, 4'h8, 8'h80);
      cyc(1'b1, 4'h9, 8'h00);
      cyc(1'b1, 4'hA, 8'hFF);
      rd_chk("level0_rb", 4'h8, 8'h80);
      cyc(1'b1, ADDR_CTRL, 8'h01);
      h0 = 0; h1 = 0; h2 = 0;
      repeat (510) begin
         cyc();
         h0 += int'(uo_out[0]);
         h1 += int'(uo_out[1]);
         h2 += int'(uo_out[2]);
      end
      check("duty_80", 32'(h0), 32'd256);
      check("duty_00", 32'(h1), 32'd0);
      check("duty_ff", 32'(h2), 32'd510);

      // PERIOD=9, PRESCALE=1, LEVEL1=3
      cyc(1'b1, ADDR_CTRL, 8'h00);
      cyc(1'b1, ADDR_PERIOD, 8'd9);
      cyc(1'b1, ADDR_PRESCALE, 8'd1);
      cyc(1'b1, 4'h9, 8'd3);
      cyc(1'b1, ADDR_CTRL, 8'h01);
      h1 = 0;
      repeat (40) begin
         cyc();
         h1 += int'(uo_out[1]);
      end
      check("p9_ps1_high", 32'(h1), 32'd12);

      // Mid-period level change on channel 2, plus a write on the wrap cycle
      cyc(1'b1, ADDR_CTRL, 8'h00);
      cyc(1'b1, ADDR_PERIOD, 8'd254);
      cyc(1'b1, ADDR_PRESCALE, 8'd0);
      cyc(1'b1, 4'hA, 8'h20);
      cyc(1'b1, ADDR_CTRL, 8'h01);
      run_to_cnt(8'd100, 400);
      cyc(1'b1, 4'hA, 8'hC0);
      rd_chk("level2_rb", 4'hA, 8'hC0);
      run_to_cnt(8'd254, 400);
      cyc(1'b1, 4'hA, 8'h40);
      h2 = 0;
      repeat (255) begin
         cyc();
         h2 += int'(uo_out[2]);
      end
      check("lvl_c0_period", 32'(h2), 32'd192);
      h2 = 0;
      repeat (255) begin
         cyc();
         h2 += int'(uo_out[2]);
      end
      check("lvl_40_period", 32'(h2), 32'd64);

      // Polarity with EN=0; channels at and above NUM_CH stay 0
      cyc(1'b1, ADDR_CTRL, 8'h00);
      cyc(1'b1, ADDR_POLARITY, 8'h05);
      cyc();
      check("pol_05_uo", 32'(uo_out), 32'h05);
      cyc(1'b1, ADDR_POLARITY, 8'hFF);
      cyc();
      rd_chk("pol_trunc_rb", ADDR_POLARITY, 8'h0F);
      check("pol_ff_uo", 32'(uo_out), 32'h0F);
      cyc(1'b1, ADDR_POLARITY, 8'h00);
      cyc(1'b1, 4'h5, 8'hAA);
      rd_chk("addr5_ignored", 4'h5, 8'h00);

      // PERIOD lowered from 200 to 50 while count=120
      cyc(1'b1, ADDR_PERIOD, 8'd200);
      cyc(1'b1, ADDR_CTRL, 8'h01);
      run_to_cnt(8'd119, 400);
      cyc(1'b1, ADDR_PERIOD, 8'd50);
      check("cnt_at_120", 32'(data_out), 32'd120);
      cyc();
      check("cnt_wrapped", 32'(data_out), 32'd0);
      repeat (60) cyc();

`ifdef TQVP_MULTI_PWM_IRQ_EN
      run_to_cnt(8'd50, 200);
      cyc();
      check("irq_set", 32'(irq), 32'h1);
      rd_chk("ctrl_flag", ADDR_CTRL, 8'h03);
      cyc(1'b1, ADDR_CTRL, 8'h03);
      check("irq_clr", 32'(irq), 32'h0);
      run_to_cnt(8'd50, 200);
      cyc(1'b1, ADDR_CTRL, 8'h03);
      check("irq_clr_on_wrap", 32'(irq), 32'h1);
`else
      run_to_cnt(8'd50, 200);
      cyc();
      check("irq_off", 32'(irq), 32'h0);
      cyc(1'b1, ADDR_CTRL, 8'h03);
      rd_chk("ctrl_no_flag", ADDR_CTRL, 8'h01);
`endif

      // Reset mid-operation overrides a same-cycle write
      rst = 1'b1; data_write = 1'b1; address = ADDR_PERIOD; data_in = 8'd5;
      @(negedge clk);
      rst = 1'b0; data_write = 1'b0;
      model_reset();
      rd_chk("rst_wr_period", ADDR_PERIOD, 8'hFE);
      rd_chk("rst_wr_ctrl", ADDR_CTRL, 8'h00);
      check("rst_wr_uo", 32'(uo_out), 32'h0);
      repeat (5) cyc();

      if (sb_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
